// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin scheduler sharing one binary-to-Gray converter among NREQ requesters.
// Latency: gnt pulses combinationally in cycle N; registered result and out_valid appear in cycle N+1.
// Backpressure: while a result is held and out_ready=0, no grant is issued and the result stays stable.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-requester request bits
//   bin_in     packed binary words, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot single-cycle grant pulse
//   out_valid  held result is valid
//   out_ready  consumer accepts the result when out_valid && out_ready
//   out_gray   registered Gray code of the granted word
//   out_id     index of the requester that produced out_gray
//   out_parity XOR of out_gray bits (present only when GRAY_CONV_PARITY_EN is defined)
//
// Build option: define GRAY_CONV_PARITY_EN to add the registered out_parity output.

module gray_conv_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      bin_in,
  output logic [NREQ-1:0]            gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_gray,
  output logic [$clog2(NREQ)-1:0]    out_id
`ifdef GRAY_CONV_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nxt;
  logic [PW-1:0]    w_win;
  logic [PW:0]      w_sum;
  logic             w_any;
  logic             w_can_accept;
  logic             w_grant;
  logic [NREQ-1:0]  w_gnt;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] r_gray;
  logic [PW-1:0]    r_id;

  // Round-robin search. Walking the offsets from highest to lowest and
  // overwriting on every hit leaves the smallest offset from r_ptr as the
  // winner, which is the first requester at or after the pointer.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      if (req[w_sum[PW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_sum[PW-1:0];
      end
    end
  end

  // A held result may be replaced in the same edge it drains, so a HOLD
  // state with out_ready high still accepts a new request.
  assign w_can_accept = (r_state == S_IDLE) || out_ready;

  // Gating with rst keeps gnt low for the whole reset window, even though
  // the state already reads IDLE during reset.
  assign w_grant = w_can_accept && w_any && !rst;
  assign w_gnt   = w_grant ? (NREQ'(1) << w_win) : '0;
  assign gnt     = w_gnt;

  assign w_bin  = bin_in[w_win*WIDTH +: WIDTH];
  assign w_gray = w_bin ^ (w_bin >> 1);

  assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_grant) begin
          w_state_nxt = S_HOLD;
        end else if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result and pointer only move on a grant; draining without a new grant
  // leaves the last result in place behind out_valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray <= '0;
      r_id   <= '0;
      r_ptr  <= '0;
    end else if (w_grant) begin
      r_gray <= w_gray;
      r_id   <= w_win;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == S_HOLD);
  assign out_gray  = r_gray;
  assign out_id    = r_id;

`ifdef GRAY_CONV_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_grant) begin
      r_parity <= ^w_gray;
    end
  end

  assign out_parity = r_parity;
`endif

endmodule
